// File: rtl/vend_dispense_arb.sv
// Two-panel drink vending arbiter: round-robin grant, stock/price check, motor pulse, Rs 5 change payout.
// Optional VEND_AUDIT_EN adds sales_1/sales_2 (wrapping) and refusals (saturating) counters.
module vend_dispense_arb #(
    parameter int PRICE_1     = 15,
    parameter int PRICE_2     = 20,
    parameter int STOCK_W     = 4,
    parameter int STOCK_INIT  = 4,
    parameter int DISP_CYCLES = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_a,
    input  logic               req_b,
    input  logic               sel_a,
    input  logic               sel_b,
    input  logic [4:0]         credit_a,
    input  logic [4:0]         credit_b,
    output logic               grant_a,
    output logic               grant_b,
    output logic               done_a,
    output logic               done_b,
    output logic               refused_a,
    output logic               refused_b,
    output logic               motor_1,
    output logic               motor_2,
    output logic               coin_5,
    output logic               busy,
    input  logic               restock,
    input  logic               restock_sel,
    input  logic [STOCK_W-1:0] restock_cnt,
    output logic               restock_ack,
    output logic [STOCK_W-1:0] stock_1,
    output logic [STOCK_W-1:0] stock_2
`ifdef VEND_AUDIT_EN
    ,
    output logic [15:0]        sales_1,
    output logic [15:0]        sales_2,
    output logic [7:0]         refusals
`endif
);

    localparam logic [4:0]         P1     = 5'(PRICE_1);
    localparam logic [4:0]         P2     = 5'(PRICE_2);
    localparam logic [STOCK_W-1:0] S_INIT = STOCK_W'(STOCK_INIT);
    localparam logic [STOCK_W-1:0] S_MAX  = '1;
    localparam int                 CW     = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;
    localparam logic [CW-1:0]      D_LAST = CW'(DISP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_DISPENSE,
        S_PAYOUT,
        S_DONE
    } state_t;

    state_t               state_q;
    logic                 ptr_q;          // 1: B wins the next tie
    logic                 panel_q;        // 0: A owns the transaction, 1: B
    logic                 sel_q;
    logic [4:0]           credit_q;
    logic [4:0]           change_q;
    logic [4:0]           coins_q;
    logic [CW-1:0]        disp_cnt_q;
    logic                 refused_flag_q;
    logic [STOCK_W-1:0]   stock_1_q;
    logic [STOCK_W-1:0]   stock_2_q;
    logic                 grant_a_q;
    logic                 grant_b_q;
    logic                 done_a_q;
    logic                 done_b_q;
    logic                 refused_a_q;
    logic                 refused_b_q;
    logic                 motor_1_q;
    logic                 motor_2_q;
    logic                 coin_5_q;
    logic                 busy_q;
    logic                 ack_q;
`ifdef VEND_AUDIT_EN
    logic [15:0]          sales_1_q;
    logic [15:0]          sales_2_q;
    logic [7:0]           refusals_q;
`endif

    logic [4:0]           price_d;
    logic [STOCK_W-1:0]   cur_stock_d;
    logic                 refuse_d;
    logic [4:0]           change_d;
    logic [4:0]           coins_chk_d;
    logic [4:0]           coins_pay_d;
    logic [STOCK_W:0]     restock_sum_d;
    logic [STOCK_W-1:0]   restock_val_d;
    logic                 pick_b_d;

    always_comb begin
        price_d       = sel_q ? P2 : P1;
        cur_stock_d   = sel_q ? stock_2_q : stock_1_q;
        refuse_d      = (cur_stock_d == '0) || (credit_q < price_d);
        change_d      = refuse_d ? credit_q : (credit_q - price_d);
        coins_chk_d   = change_d / 5'd5;
        coins_pay_d   = change_q / 5'd5;
        restock_sum_d = {1'b0, (restock_sel ? stock_2_q : stock_1_q)} + {1'b0, restock_cnt};
        restock_val_d = restock_sum_d[STOCK_W] ? S_MAX : restock_sum_d[STOCK_W-1:0];
        pick_b_d      = req_b & (~req_a | ptr_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            ptr_q          <= 1'b0;
            panel_q        <= 1'b0;
            sel_q          <= 1'b0;
            credit_q       <= '0;
            change_q       <= '0;
            coins_q        <= '0;
            disp_cnt_q     <= '0;
            refused_flag_q <= 1'b0;
            stock_1_q      <= S_INIT;
            stock_2_q      <= S_INIT;
            grant_a_q      <= 1'b0;
            grant_b_q      <= 1'b0;
            done_a_q       <= 1'b0;
            done_b_q       <= 1'b0;
            refused_a_q    <= 1'b0;
            refused_b_q    <= 1'b0;
            motor_1_q      <= 1'b0;
            motor_2_q      <= 1'b0;
            coin_5_q       <= 1'b0;
            busy_q         <= 1'b0;
            ack_q          <= 1'b0;
`ifdef VEND_AUDIT_EN
            sales_1_q      <= '0;
            sales_2_q      <= '0;
            refusals_q     <= '0;
`endif
        end else begin
            grant_a_q   <= 1'b0;
            grant_b_q   <= 1'b0;
            done_a_q    <= 1'b0;
            done_b_q    <= 1'b0;
            refused_a_q <= 1'b0;
            refused_b_q <= 1'b0;
            ack_q       <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // Restock takes priority; a pending request is served next cycle.
                    if (restock) begin
                        if (restock_sel) stock_2_q <= restock_val_d;
                        else             stock_1_q <= restock_val_d;
                        ack_q <= 1'b1;
                    end else if (req_a || req_b) begin
                        panel_q        <= pick_b_d;
                        grant_a_q      <= ~pick_b_d;
                        grant_b_q      <= pick_b_d;
                        sel_q          <= pick_b_d ? sel_b : sel_a;
                        credit_q       <= pick_b_d ? credit_b : credit_a;
                        refused_flag_q <= 1'b0;
                        busy_q         <= 1'b1;
                        state_q        <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    change_q <= change_d;
                    if (refuse_d) begin
                        refused_flag_q <= 1'b1;
                        coins_q        <= coins_chk_d;
                        coin_5_q       <= (coins_chk_d != '0);
                        state_q        <= S_PAYOUT;
`ifdef VEND_AUDIT_EN
                        if (refusals_q != 8'hFF) refusals_q <= refusals_q + 8'd1;
`endif
                    end else begin
                        if (sel_q) stock_2_q <= stock_2_q - 1'b1;
                        else       stock_1_q <= stock_1_q - 1'b1;
                        motor_1_q  <= ~sel_q;
                        motor_2_q  <= sel_q;
                        disp_cnt_q <= D_LAST;
                        state_q    <= S_DISPENSE;
`ifdef VEND_AUDIT_EN
                        if (sel_q) sales_2_q <= sales_2_q + 16'd1;
                        else       sales_1_q <= sales_1_q + 16'd1;
`endif
                    end
                end
                S_DISPENSE: begin
                    if (disp_cnt_q == '0) begin
                        motor_1_q <= 1'b0;
                        motor_2_q <= 1'b0;
                        coins_q   <= coins_pay_d;
                        coin_5_q  <= (coins_pay_d != '0);
                        state_q   <= S_PAYOUT;
                    end else begin
                        disp_cnt_q <= disp_cnt_q - CW'(1);
                    end
                end
                S_PAYOUT: begin
                    // coins_q counts coins not yet finished, including the one on the wire.
                    if (coin_5_q) begin
                        coin_5_q <= 1'b0;
                        coins_q  <= coins_q - 5'd1;
                    end else if (coins_q != '0) begin
                        coin_5_q <= 1'b1;
                    end else begin
                        done_a_q    <= ~panel_q;
                        done_b_q    <= panel_q;
                        refused_a_q <= refused_flag_q & ~panel_q;
                        refused_b_q <= refused_flag_q & panel_q;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    ptr_q   <= ~panel_q;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign grant_a     = grant_a_q;
    assign grant_b     = grant_b_q;
    assign done_a      = done_a_q;
    assign done_b      = done_b_q;
    assign refused_a   = refused_a_q;
    assign refused_b   = refused_b_q;
    assign motor_1     = motor_1_q;
    assign motor_2     = motor_2_q;
    assign coin_5      = coin_5_q;
    assign busy        = busy_q;
    assign restock_ack = ack_q;
    assign stock_1     = stock_1_q;
    assign stock_2     = stock_2_q;
`ifdef VEND_AUDIT_EN
    assign sales_1     = sales_1_q;
    assign sales_2     = sales_2_q;
    assign refusals    = refusals_q;
`endif

endmodule
